// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg
// Shared definitions for the 68000 bus sequencer:
//   - bus_state_t        : sequencer state encoding
//   - LANES_*            : byte-lane codes ({upper, lower})
//   - TIMEOUT_CYCLES_DEF : default WAIT-state budget before a forced bus error
//   - lane_decode()      : maps the core's byte_ena onto active data strobes
package m68k_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_STROBE  = 3'd2,
      ST_WDATA   = 3'd3,
      ST_WAIT    = 3'd4,
      ST_ACK     = 3'd5,
      ST_RELEASE = 3'd6
   } bus_state_t;

   localparam int         TIMEOUT_CYCLES_DEF = 64;

   localparam logic [1:0] LANES_NONE  = 2'b00;
   localparam logic [1:0] LANES_BOTH  = 2'b11;

   // The core signals a full word access with byte_ena = 00, so an empty
   // lane mask means both lanes.
   function automatic logic [1:0] lane_decode(input logic [1:0] be);
      logic [1:0] lanes;
      if (be == LANES_NONE) begin
         lanes = LANES_BOTH;
      end else begin
         lanes = be;
      end
      return lanes;
   endfunction

endpackage

// File: rtl/m68k_bus_sequencer_timeout.sv
// bus_timeout
// Loadable down-counter that flags a hung bus cycle. Only instantiated when
// BUS_TIMEOUT_EN is defined.
//   clk, rst  : clock, synchronous active-high reset
//   load      : reload the counter with load_val (WAIT entry)
//   load_val  : reload value (cycle budget minus one)
//   en        : count enable (sequencer is in WAIT)
//   expire    : high during the last budgeted WAIT cycle
module bus_timeout #(
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             expire
);

   logic [WIDTH-1:0] cnt_r;

   // Down-counter: reload on WAIT entry, count while waiting, park at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (en && (cnt_r != '0)) begin
         cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = en && (cnt_r == '0);

endmodule

// File: rtl/m68k_bus_sequencer.sv
// m68k_bus_sequencer
// Turns the j68 core's held rd_ena/wr_ena request into a 68000 asynchronous
// bus cycle (IDLE-ADDR-STROBE-[WDATA]-WAIT-ACK-RELEASE). Address, FC and R_Wn
// are set up one cycle before ASn; on writes data is driven one cycle before
// UDSn/LDSn. All bus and core outputs are registered.
// Optional feature: define BUS_TIMEOUT_EN to end a cycle with bus_err after
// TIMEOUT_CYCLES WAIT cycles without DTACKn/BERRn.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rd_ena, wr_ena        : core requests (write wins if both high)
//   byte_ena              : {upper, lower} lanes, 00 = word
//   address, wr_data, fc_in : request attributes, latched on acceptance
//   rd_data               : read data latched on DTACKn
//   data_ack, bus_err     : one-cycle completion / error pulses
//   addr, FC, R_Wn        : bus address [23:1], function code, direction
//   data_out, data_oe     : bus write data and its drive enable
//   data_in               : bus read data
//   ASn, UDSn, LDSn       : active-low strobes
//   DTACKn, BERRn         : active-low terminations, already synchronized
module m68k_bus_sequencer
   import m68k_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_ena,
   input  logic        wr_ena,
   input  logic [1:0]  byte_ena,
   input  logic [31:0] address,
   input  logic [15:0] wr_data,
   input  logic [2:0]  fc_in,
   output logic [15:0] rd_data,
   output logic        data_ack,
   output logic        bus_err,
   output logic [22:0] addr,
   output logic [15:0] data_out,
   output logic        data_oe,
   input  logic [15:0] data_in,
   output logic        ASn,
   output logic        UDSn,
   output logic        LDSn,
   output logic        R_Wn,
   output logic [2:0]  FC,
   input  logic        DTACKn,
   input  logic        BERRn
);

   bus_state_t  state_r, state_next_s;
   logic        err_r, err_next_s;
   logic        write_r;
   logic [1:0]  lanes_r;
   logic [22:0] addr_r;
   logic [2:0]  fc_r;
   logic [15:0] data_out_r;
   logic [15:0] rd_data_r;
   logic        as_n_r, uds_n_r, lds_n_r, r_wn_r, data_oe_r;
   logic        data_ack_r, bus_err_r;

   logic        accept_s, latch_rd_s, write_next_s, timeout_s;
   logic        as_n_next_s, ds_act_next_s, r_wn_next_s, data_oe_next_s;

   logic        unused_s;
   assign unused_s = ^{address[31:24], address[0]};

`ifdef BUS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic to_load_s;
   assign to_load_s = (state_next_s == ST_WAIT) && (state_r != ST_WAIT);

   bus_timeout #(.WIDTH(TO_W)) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .load     (to_load_s),
      .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
      .en       (state_r == ST_WAIT),
      .expire   (timeout_s)
   );
`else
   // Without the timeout the WAIT state is unbounded.
   logic [31:0] unused_to_s;
   assign unused_to_s = TIMEOUT_CYCLES;
   assign timeout_s   = 1'b0;
`endif

   // Next-state logic; BERRn beats DTACKn, and DTACKn beats the timeout.
   always_comb begin
      state_next_s = state_r;
      err_next_s   = err_r;
      accept_s     = 1'b0;
      latch_rd_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rd_ena || wr_ena) begin
               accept_s     = 1'b1;
               err_next_s   = 1'b0;
               state_next_s = ST_ADDR;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ADDR:   state_next_s = ST_STROBE;
         ST_STROBE: begin
            if (write_r) begin
               state_next_s = ST_WDATA;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_WDATA:  state_next_s = ST_WAIT;
         ST_WAIT: begin
            if (!BERRn) begin
               err_next_s   = 1'b1;
               state_next_s = ST_ACK;
            end else if (!DTACKn) begin
               latch_rd_s   = !write_r;
               state_next_s = ST_ACK;
            end else if (timeout_s) begin
               err_next_s   = 1'b1;
               state_next_s = ST_ACK;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_ACK:     state_next_s = ST_RELEASE;
         ST_RELEASE: state_next_s = ST_IDLE;
         default:    state_next_s = ST_IDLE;
      endcase
   end

   // Output decode from the next state, so the registered bus pins change
   // on the same edge the state does.
   always_comb begin
      write_next_s   = accept_s ? wr_ena : write_r;
      as_n_next_s    = 1'b1;
      ds_act_next_s  = 1'b0;
      r_wn_next_s    = 1'b1;
      data_oe_next_s = 1'b0;
      case (state_next_s)
         ST_ADDR: begin
            r_wn_next_s = !write_next_s;
         end
         ST_STROBE: begin
            as_n_next_s    = 1'b0;
            ds_act_next_s  = !write_next_s;
            r_wn_next_s    = !write_next_s;
            data_oe_next_s = write_next_s;
         end
         ST_WDATA, ST_WAIT: begin
            as_n_next_s    = 1'b0;
            ds_act_next_s  = 1'b1;
            r_wn_next_s    = !write_next_s;
            data_oe_next_s = write_next_s;
         end
         ST_ACK: begin
            // Strobes are up; data stays driven one more cycle for hold.
            r_wn_next_s    = !write_next_s;
            data_oe_next_s = write_next_s;
         end
         default: begin
            as_n_next_s    = 1'b1;
            ds_act_next_s  = 1'b0;
            r_wn_next_s    = 1'b1;
            data_oe_next_s = 1'b0;
         end
      endcase
   end

   // State, request latches and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         err_r      <= 1'b0;
         write_r    <= 1'b0;
         lanes_r    <= LANES_NONE;
         addr_r     <= 23'd0;
         fc_r       <= 3'd0;
         data_out_r <= 16'd0;
         rd_data_r  <= 16'd0;
         as_n_r     <= 1'b1;
         uds_n_r    <= 1'b1;
         lds_n_r    <= 1'b1;
         r_wn_r     <= 1'b1;
         data_oe_r  <= 1'b0;
         data_ack_r <= 1'b0;
         bus_err_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         err_r   <= err_next_s;
         if (accept_s) begin
            write_r    <= wr_ena;
            lanes_r    <= lane_decode(byte_ena);
            addr_r     <= address[23:1];
            fc_r       <= fc_in;
            data_out_r <= wr_data;
         end
         if (latch_rd_s) begin
            rd_data_r <= data_in;
         end
         as_n_r     <= as_n_next_s;
         uds_n_r    <= !(ds_act_next_s && lanes_r[1]);
         lds_n_r    <= !(ds_act_next_s && lanes_r[0]);
         r_wn_r     <= r_wn_next_s;
         data_oe_r  <= data_oe_next_s;
         data_ack_r <= (state_next_s == ST_ACK) && !err_next_s;
         bus_err_r  <= (state_next_s == ST_ACK) && err_next_s;
      end
   end

   assign rd_data  = rd_data_r;
   assign data_ack = data_ack_r;
   assign bus_err  = bus_err_r;
   assign addr     = addr_r;
   assign FC       = fc_r;
   assign data_out = data_out_r;
   assign data_oe  = data_oe_r;
   assign ASn      = as_n_r;
   assign UDSn     = uds_n_r;
   assign LDSn     = lds_n_r;
   assign R_Wn     = r_wn_r;

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// tb_m68k_bus_sequencer
// Directed bench for m68k_bus_sequencer. Inputs change and outputs are
// sampled 1 ns after each rising edge; "edge N" counts from the edge that
// accepts the request (edge 0). Build with BUS_TIMEOUT_EN to exercise the
// timeout path (TIMEOUT_CYCLES = 8).
module tb_m68k_bus_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_ena, wr_ena;
   logic [1:0]  byte_ena;
   logic [31:0] address;
   logic [15:0] wr_data;
   logic [2:0]  fc_in;
   logic [15:0] rd_data;
   logic        data_ack, bus_err;
   logic [22:0] addr;
   logic [15:0] data_out;
   logic        data_oe;
   logic [15:0] data_in;
   logic        ASn, UDSn, LDSn, R_Wn;
   logic [2:0]  FC;
   logic        DTACKn, BERRn;

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   m68k_bus_sequencer #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .rd_ena(rd_ena), .wr_ena(wr_ena),
      .byte_ena(byte_ena), .address(address), .wr_data(wr_data),
      .fc_in(fc_in), .rd_data(rd_data), .data_ack(data_ack),
      .bus_err(bus_err), .addr(addr), .data_out(data_out),
      .data_oe(data_oe), .data_in(data_in), .ASn(ASn), .UDSn(UDSn),
      .LDSn(LDSn), .R_Wn(R_Wn), .FC(FC), .DTACKn(DTACKn), .BERRn(BERRn)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // {ASn, UDSn, LDSn, R_Wn, data_oe} in one compare.
   task automatic check_bus(input string tag, input logic [4:0] exp);
      check_val(tag, {27'd0, ASn, UDSn, LDSn, R_Wn, data_oe}, {27'd0, exp});
   endtask

   task automatic start_req(input logic rd, input logic wr, input logic [1:0] be,
                            input logic [31:0] a, input logic [15:0] wd,
                            input logic [2:0] fc);
      rd_ena   = rd;
      wr_ena   = wr;
      byte_ena = be;
      address  = a;
      wr_data  = wd;
      fc_in    = fc;
   endtask

   task automatic drop_req();
      rd_ena = 1'b0;
      wr_ena = 1'b0;
   endtask

   initial begin
      rst = 1'b1; drop_req(); byte_ena = 2'b00; address = 32'd0;
      wr_data = 16'd0; fc_in = 3'd0; data_in = 16'd0;
      DTACKn = 1'b1; BERRn = 1'b1;
      tick(); tick();
      check_bus("reset strobes", 5'b11110);
      check_val("reset acks", {30'd0, data_ack, bus_err}, 32'd0);
      check_val("reset rd_data", {16'd0, rd_data}, 32'd0);
      check_val("reset addr", {9'd0, addr}, 32'd0);
      check_val("reset fc/dout", {13'd0, FC, data_out}, 32'd0);
      rst = 1'b0;
      tick();

      // Zero-wait word read at 0x001000.
      DTACKn = 1'b0; data_in = 16'hBEEF;
      start_req(1'b1, 1'b0, 2'b11, 32'h0000_1000, 16'h0000, 3'd6);
      tick(); // edge 0 -> ADDR
      check_val("rd addr", {9'd0, addr}, 32'h0000_0800);
      check_val("rd fc", {29'd0, FC}, 32'd6);
      check_bus("rd ADDR", 5'b11110);
      tick(); // edge 1 -> STROBE
      check_bus("rd STROBE", 5'b00010);
      tick(); // edge 2 -> WAIT
      check_val("rd no early ack", {31'd0, data_ack}, 32'd0);
      tick(); // edge 3 -> ACK
      check_val("rd ack", {30'd0, data_ack, bus_err}, 32'd2);
      check_val("rd data", {16'd0, rd_data}, 32'h0000_BEEF);
      check_bus("rd ACK", 5'b11110);
      drop_req();
      tick(); // edge 4 -> RELEASE
      check_val("rd ack one cycle", {31'd0, data_ack}, 32'd0);
      tick(); // edge 5 -> IDLE

      // Lower-byte write, DTACKn arrives after 3 wait cycles.
      DTACKn = 1'b1;
      start_req(1'b0, 1'b1, 2'b01, 32'h0000_2002, 16'h00A5, 3'd5);
      tick(); // edge 0 -> ADDR
      check_bus("wr ADDR", 5'b11100);
      check_val("wr addr", {9'd0, addr}, 32'h0000_1001);
      tick(); // edge 1 -> STROBE
      check_bus("wr STROBE", 5'b01101);
      check_val("wr dout strobe", {16'd0, data_out}, 32'h0000_00A5);
      tick(); // edge 2 -> WDATA
      check_bus("wr WDATA", 5'b01001);
      tick(); // edge 3 -> WAIT
      for (int i = 0; i < 3; i++) begin
         tick(); // edges 4..6 stay in WAIT
         check_bus("wr WAIT", 5'b01001);
         check_val("wr dout wait", {15'd0, data_ack, data_out}, 32'h0000_00A5);
      end
      DTACKn = 1'b0;
      tick(); // edge 7 -> ACK
      check_val("wr ack", {30'd0, data_ack, bus_err}, 32'd2);
      check_bus("wr ACK", 5'b11101);
      check_val("wr dout ack", {16'd0, data_out}, 32'h0000_00A5);
      check_val("wr rd_data kept", {16'd0, rd_data}, 32'h0000_BEEF);
      drop_req();
      tick(); // edge 8 -> RELEASE
      check_bus("wr RELEASE", 5'b11110);
      tick();

      // Upper-byte read with BERRn and DTACKn low together.
      BERRn = 1'b0; DTACKn = 1'b0; data_in = 16'h1234;
      start_req(1'b1, 1'b0, 2'b10, 32'h0000_0400, 16'h0000, 3'd1);
      tick(); tick(); // edge 1 -> STROBE
      check_bus("berr STROBE", 5'b00110);
      tick(); tick(); // edge 3 -> ACK
      check_val("berr pulse", {30'd0, data_ack, bus_err}, 32'd1);
      check_val("berr rd_data", {16'd0, rd_data}, 32'h0000_BEEF);
      drop_req(); BERRn = 1'b1;
      tick();
      check_val("berr one cycle", {31'd0, bus_err}, 32'd0);
      tick();

      // Reset while waiting, then a fresh read.
      DTACKn = 1'b1;
      start_req(1'b1, 1'b0, 2'b00, 32'h0000_0010, 16'h0000, 3'd2);
      tick(); tick(); tick(); // edge 2 -> WAIT
      check_bus("pre-rst WAIT", 5'b00010);
      rst = 1'b1;
      tick();
      check_bus("rst release", 5'b11110);
      check_val("rst no ack", {30'd0, data_ack, bus_err}, 32'd0);
      rst = 1'b0; DTACKn = 1'b0; data_in = 16'h5A5A;
      tick(); tick(); tick(); tick(); // edge 3 -> ACK
      check_val("post-rst ack", {31'd0, data_ack}, 32'd1);
      check_val("post-rst data", {16'd0, rd_data}, 32'h0000_5A5A);
      drop_req();
      tick(); tick();

      // rd_ena and wr_ena together: write, byte_ena 00 drives both lanes.
      start_req(1'b1, 1'b1, 2'b00, 32'h0000_0020, 16'hC3C3, 3'd5);
      tick(); // edge 0
      check_val("both R_Wn", {31'd0, R_Wn}, 32'd0);
      tick(); tick(); // edge 2 -> WDATA
      check_bus("both WDATA", 5'b00001);
      tick(); tick(); // edge 4 -> ACK
      check_val("both ack", {31'd0, data_ack}, 32'd1);
      drop_req();
      tick(); tick();

`ifdef BUS_TIMEOUT_EN
      // Hung read: bus_err on the 8th WAIT cycle.
      DTACKn = 1'b1;
      start_req(1'b1, 1'b0, 2'b11, 32'h0000_0100, 16'h0000, 3'd1);
      tick(); tick(); tick(); // edge 2 -> WAIT
      for (int i = 0; i < 7; i++) tick(); // edges 3..9
      check_val("to not yet", {30'd0, bus_err, ASn}, 32'd0);
      tick(); // edge 10
      check_val("to pulse", {30'd0, data_ack, bus_err}, 32'd1);
      check_bus("to release", 5'b11110);
      drop_req();
      tick(); tick();
      // DTACKn on the timeout cycle wins.
      start_req(1'b1, 1'b0, 2'b11, 32'h0000_0100, 16'h0000, 3'd1);
      data_in = 16'h7777;
      tick(); tick(); tick();
      for (int i = 0; i < 7; i++) tick();
      DTACKn = 1'b0;
      tick();
      check_val("to dtack wins", {30'd0, data_ack, bus_err}, 32'd2);
      check_val("to dtack data", {16'd0, rd_data}, 32'h0000_7777);
      drop_req();
      tick(); tick();
`else
      // Without timeout: WAIT persists until BERRn.
      DTACKn = 1'b1;
      start_req(1'b1, 1'b0, 2'b11, 32'h0000_0100, 16'h0000, 3'd1);
      tick(); tick(); tick();
      for (int i = 0; i < 20; i++) tick();
      check_val("no-to still wait", {30'd0, bus_err, ASn}, 32'd0);
      BERRn = 1'b0;
      tick();
      check_val("no-to berr", {30'd0, data_ack, bus_err}, 32'd1);
      drop_req(); BERRn = 1'b1;
      tick(); tick();
`endif

      // Next request accepted normally.
      DTACKn = 1'b0; data_in = 16'h0F0F;
      start_req(1'b1, 1'b0, 2'b11, 32'h0000_0200, 16'h0000, 3'd1);
      tick(); tick(); tick(); tick();
      check_val("final ack", {31'd0, data_ack}, 32'd1);
      check_val("final data", {16'd0, rd_data}, 32'h0000_0F0F);
      drop_req();
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
